rotary_decoder: RTL

ROTARY_DECODER -- requirements
Module: rotary_decoder

---
 rtl/rotary_decoder_pkg.sv | 17 +
 rtl/rotary_debounce.sv | 41 ++++
 rtl/rotary_decoder.sv | 103 ++++++++++
 3 files changed

// File: rtl/rotary_decoder_pkg.sv
// Shared types and constants for the quadrature rotary encoder decoder.
package rotary_decoder_pkg;

  localparam int DEBOUNCE_CYCLES_DEFAULT = 1000;

  typedef enum logic [2:0] {
    REST,
    R1,
    R2,
    R3,
    L1,
    L2,
    L3,
    SYNC
  } state_t;

endpackage

// File: rtl/rotary_debounce.sv
// One encoder channel: 2-flop synchronizer followed by a stability filter that
// only follows the input after DEBOUNCE_CYCLES consecutive differing clocks.
module rotary_debounce
  import rotary_decoder_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic filtered
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          meta;
  logic          sync;
  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta     <= 1'b1;
      sync     <= 1'b1;
      filtered <= 1'b1;
      count    <= '0;
    end else begin
      meta <= raw;
      sync <= meta;
      // count holds (differing clocks so far - 1) on the clock being evaluated
      if (sync == filtered) begin
        count <= '0;
      end else if (count == CW'(DEBOUNCE_CYCLES - 1)) begin
        filtered <= ~filtered;
        count    <= '0;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/rotary_decoder.sv
// Rotary encoder decoder: debounces A/B and tracks the quadrature sequence,
// pulsing rotary_event once per completed detent.
module rotary_decoder
  import rotary_decoder_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic CLK,
  input  logic reset,
  input  logic rotary_a,
  input  logic rotary_b,
  output logic rotary_event,
  output logic rotary_right
);

  logic   filt_a;
  logic   filt_b;
  logic   [1:0] ab;
  state_t state;

  rotary_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
    .clk      (CLK),
    .reset    (reset),
    .raw      (rotary_a),
    .filtered (filt_a)
  );

  rotary_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
    .clk      (CLK),
    .reset    (reset),
    .raw      (rotary_b),
    .filtered (filt_b)
  );

  assign ab = {filt_a, filt_b};

  // rotary_event is a single-cycle strobe; rotary_right is qualified by it and
  // holds its value until the next strobe. There is no back-pressure.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state        <= REST;
      rotary_event <= 1'b0;
      rotary_right <= 1'b0;
    end else begin
      rotary_event <= 1'b0;
      unique case (state)
        REST: case (ab)
          2'b01:   state <= R1;
          2'b10:   state <= L1;
          2'b00:   state <= SYNC;
          default: ;
        endcase
        R1: case (ab)
          2'b00:   state <= R2;
          2'b11:   state <= REST;
          2'b10:   state <= SYNC;
          default: ;
        endcase
        R2: case (ab)
          2'b10:   state <= R3;
          2'b01:   state <= R1;
          2'b11:   state <= SYNC;
          default: ;
        endcase
        R3: case (ab)
          2'b11: begin
            state        <= REST;
            rotary_event <= 1'b1;
            rotary_right <= 1'b1;
          end
          2'b00:   state <= R2;
          2'b01:   state <= SYNC;
          default: ;
        endcase
        L1: case (ab)
          2'b00:   state <= L2;
          2'b11:   state <= REST;
          2'b01:   state <= SYNC;
          default: ;
        endcase
        L2: case (ab)
          2'b01:   state <= L3;
          2'b10:   state <= L1;
          2'b11:   state <= SYNC;
          default: ;
        endcase
        L3: case (ab)
          2'b11: begin
            state        <= REST;
            rotary_event <= 1'b1;
            rotary_right <= 1'b0;
          end
          2'b00:   state <= L2;
          2'b10:   state <= SYNC;
          default: ;
        endcase
        SYNC: if (ab == 2'b11) state <= REST;
        default: state <= SYNC;
      endcase
    end
  end

endmodule
